program_memory_loader: RTL and testbench

- Controller that owns the program-memory port: boots the program image from a byte stream, then hands the port to the CPU fetch path.
- Holds the CPU in stall while loading.
- In RUN, converts the fetch PC (text base 0x0040_0000) to a word index, and flags misaligned or out-of-window PCs.
- Sits between the IF stage and a synchronous-write variant of the program memory.

---
 rtl/program_loader_pkg.sv | 17 +
 rtl/program_memory_loader_byte_word_assembler.sv | 35 +++
 rtl/program_memory_loader.sv | 160 ++++++++++++++++
 tb/tb_program_memory_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program memory loader.
package program_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        RUN,
        FAULT
    } loader_state_t;

    localparam logic [31:0]  TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam int unsigned  HDR_BYTES         = 2;
    localparam int unsigned  WORD_BYTES        = 4;

endpackage

// File: rtl/program_memory_loader_byte_word_assembler.sv
// Packs big-endian boot bytes into a word; word_valid pulses the cycle after the last byte.
module byte_word_assembler
    import program_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic [8*WORD_BYTES-1:0] word,
    output logic                    word_valid
);

    logic [$clog2(WORD_BYTES)-1:0] fill;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            fill       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                word <= {word[8*WORD_BYTES-9:0], byte_data};
                if (fill == $clog2(WORD_BYTES)'(WORD_BYTES - 1)) begin
                    fill       <= '0;
                    word_valid <= 1'b1;
                end else begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/program_memory_loader.sv
// Boot loader owning the program-memory port, then handing it to the fetch path.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_memory_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH = 256,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter logic [31:0] TEXT_BASE    = TEXT_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  boot_start_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_we_o,
    output logic                  cpu_stall_o,
    output logic                  load_done_o,
    output logic                  pc_fault_o,
    output logic                  fault_o
);

    loader_state_t         state;
    logic [15:0]           count;
    logic [ADDR_WIDTH-1:0] widx;
    logic                  load_done_q;
    logic                  fault_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    logic                  accept;
    logic                  restart;
    logic                  last_word;
    logic [15:0]           hdr_count;
    logic [31:0]           asm_word;
    logic                  asm_valid;
    logic [DATA_WIDTH-1:0] pc_off;
    logic [DATA_WIDTH-1:0] pc_word;

    assign accept    = byte_valid_i & byte_ready_o;
    assign restart   = boot_start_i && (state == RUN || state == FAULT);
    assign hdr_count = {count[15:8], byte_data_i};
    assign last_word = (32'(widx) == 32'(count) - 32'd1);
    assign pc_off    = pc_i - DATA_WIDTH'(TEXT_BASE);
    assign pc_word   = pc_off >> 2;

    byte_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_valid (accept && state == DATA),
        .byte_data  (byte_data_i),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    // The write cycle is the one after the 4th byte; ready drops for it.
    always_comb begin
        byte_ready_o = 1'b0;
        case (state)
            HDR_HI, HDR_LO, DATA: byte_ready_o = !asm_valid;
`ifdef LOADER_CHECKSUM_EN
            CSUM:                 byte_ready_o = 1'b1;
`endif
            default:              byte_ready_o = 1'b0;
        endcase
    end

    assign mem_we_o    = asm_valid && (state == DATA);
    assign mem_wdata_o = DATA_WIDTH'(asm_word);
    assign mem_addr_o  = (state == RUN) ? pc_word[ADDR_WIDTH-1:0] : widx;
    assign cpu_stall_o = (state != RUN);
    assign load_done_o = load_done_q;
    assign fault_o     = fault_q;
    assign pc_fault_o  = (state == RUN) &&
                         ((pc_i[1:0] != 2'b00) ||
                          (pc_i < DATA_WIDTH'(TEXT_BASE)) ||
                          (pc_word >= DATA_WIDTH'(count)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HDR_HI;
            count       <= '0;
            widx        <= '0;
            load_done_q <= 1'b0;
            fault_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            load_done_q <= 1'b0;
            case (state)
                HDR_HI: begin
                    if (accept) begin
                        count[15:8] <= byte_data_i;
                        state       <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        count[7:0] <= byte_data_i;
                        if (hdr_count == 16'd0 || 32'(hdr_count) > 32'(MEMORY_DEPTH)) begin
                            state   <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state <= DATA;
                            widx  <= '0;
`ifdef LOADER_CHECKSUM_EN
                            csum  <= '0;
`endif
                        end
                    end
                end
                DATA: begin
`ifdef LOADER_CHECKSUM_EN
                    if (accept)
                        csum <= csum ^ byte_data_i;
`endif
                    if (mem_we_o) begin
                        widx <= widx + 1'b1;
                        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            state       <= RUN;
                            load_done_q <= 1'b1;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        if (byte_data_i == csum) begin
                            state       <= RUN;
                            load_done_q <= 1'b1;
                        end else begin
                            state   <= FAULT;
                            fault_q <= 1'b1;
                        end
                    end
                end
`endif
                RUN, FAULT: begin
                    if (boot_start_i) begin
                        state   <= HDR_HI;
                        fault_q <= 1'b0;
                    end
                end
                default: state <= HDR_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader; stream/PC expectations come from a behavioural model.
module tb_program_memory_loader;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        boot_start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = '0;
    logic        byte_ready_o;
    logic [31:0] pc_i = '0;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_we_o;
    logic        cpu_stall_o;
    logic        load_done_o;
    logic        pc_fault_o;
    logic        fault_o;

    int unsigned tests = 0;
    int unsigned fails = 0;

    program_memory_loader #(
        .MEMORY_DEPTH (256),
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (8),
        .TEXT_BASE    (BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .boot_start_i (boot_start_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .pc_i         (pc_i),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_we_o     (mem_we_o),
        .cpu_stall_o  (cpu_stall_o),
        .load_done_o  (load_done_o),
        .pc_fault_o   (pc_fault_o),
        .fault_o      (fault_o)
    );

    always #5 clk = ~clk;

    // Passive monitor: records writes and event cycles, sampled on the falling edge.
    logic [39:0] obs[$];
    int unsigned cyc = 0, last_we_cyc = 0, done_cyc = 0, fall_cyc = 0;
    int unsigned done_cnt = 0, we_double = 0;
    logic        prev_we = 1'b0, prev_stall = 1'b1;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_we_o) begin
            obs.push_back({mem_addr_o, mem_wdata_o});
            last_we_cyc = cyc;
            if (prev_we) we_double = we_double + 1;
        end
        if (load_done_o) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (prev_stall && !cpu_stall_o) fall_cyc = cyc;
        prev_we    = mem_we_o;
        prev_stall = cpu_stall_o;
    end

    logic [31:0] img [DEPTH];

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int unsigned waits = 0;
        bit done = 0;
        while (!done) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                byte_valid_i = 1'b0;
                byte_data_i  = 8'($urandom);
            end else begin
                byte_valid_i = 1'b1;
                byte_data_i  = b;
                if (byte_ready_o) done = 1;
            end
            waits++;
            if (!done && waits > 60) begin
                check("byte_accept_timeout", 40'(waits), 40'd0);
                done = 1;
            end
        end
    endtask

    task automatic idle_bus();
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic boot_pulse();
        @(negedge clk);
        boot_start_i = 1'b1;
        @(negedge clk);
        boot_start_i = 1'b0;
        check("boot_stall", 40'(cpu_stall_o), 40'd1);
        check("boot_ready", 40'(byte_ready_o), 40'd1);
        check("boot_fault_clr", 40'(fault_o), 40'd0);
    endtask

    // Streams header + img[0..n-1] (+ checksum) and checks the resulting writes.
    task automatic load_image(input int unsigned n, input bit gaps);
        int unsigned base = obs.size();
        int unsigned done0 = done_cnt;
        int unsigned dbl0 = we_double;
        int unsigned w = 0;
        logic [7:0] x = 8'h00;
        logic [31:0] word;
        send_byte(8'(n >> 8), gaps);
        send_byte(8'(n), gaps);
        for (int unsigned i = 0; i < n; i++) begin
            word = img[i];
            for (int unsigned k = 0; k < 4; k++) begin
                send_byte(word[31 - 8*k -: 8], gaps);
                x = x ^ word[31 - 8*k -: 8];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, gaps);
`endif
        idle_bus();
        while (cpu_stall_o && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("run_reached", 40'(cpu_stall_o), 40'd0);
        @(negedge clk);
        @(negedge clk);
        check("write_count", 40'(obs.size() - base), 40'(n));
        for (int unsigned i = 0; i < n && base + i < obs.size(); i++)
            check("write_word", obs[base + i], {8'(i), img[i]});
        check("done_pulses", 40'(done_cnt - done0), 40'd1);
        check("we_single_cycle", 40'(we_double - dbl0), 40'd0);
        check("run_ready", 40'(byte_ready_o), 40'd0);
`ifndef LOADER_CHECKSUM_EN
        check("stall_latency", 40'(fall_cyc), 40'(last_we_cyc + 1));
        check("done_latency", 40'(done_cyc), 40'(last_we_cyc + 1));
`endif
    endtask

    task automatic pc_check(input logic [31:0] pc, input int unsigned n);
        logic [31:0] off;
        bit exp_fault;
        @(negedge clk);
        pc_i = pc;
        #1;
        off = (pc - BASE) / 4;
        exp_fault = (pc % 4 != 0) || (pc < BASE) || (off >= n);
        check("pc_fault", 40'(pc_fault_o), 40'(exp_fault));
        check("pc_addr", 40'(mem_addr_o), 40'(off % 256));
    endtask

    task automatic random_pcs(input int unsigned n, input int unsigned k);
        for (int unsigned i = 0; i < k; i++) begin
            case ($urandom_range(0, 2))
                0: pc_check(BASE + 32'($urandom_range(0, 4*n + 12)), n);
                1: pc_check(BASE - 32'($urandom_range(1, 16)), n);
                default: pc_check($urandom, n);
            endcase
        end
    endtask

    task automatic bad_header(input logic [7:0] hi, input logic [7:0] lo);
        send_byte(hi, 1'b0);
        send_byte(lo, 1'b0);
        idle_bus();
        check("hdr_fault", 40'(fault_o), 40'd1);
        check("hdr_fault_stall", 40'(cpu_stall_o), 40'd1);
        check("hdr_fault_ready", 40'(byte_ready_o), 40'd0);
        check("hdr_fault_pcfault", 40'(pc_fault_o), 40'd0);
        repeat (3) @(negedge clk);
        check("hdr_fault_sticky", 40'(fault_o), 40'd1);
    endtask

    initial begin
        int unsigned n;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_stall", 40'(cpu_stall_o), 40'd1);
        check("rst_ready", 40'(byte_ready_o), 40'd1);
        check("rst_we", 40'(mem_we_o), 40'd0);
        check("rst_done", 40'(load_done_o), 40'd0);
        check("rst_fault", 40'(fault_o), 40'd0);
        check("rst_pcfault", 40'(pc_fault_o), 40'd0);
        check("rst_addr", 40'(mem_addr_o), 40'd0);

        // Directed two-word image
        img[0] = 32'h2008_0005;
        img[1] = 32'h0000_000C;
        load_image(2, 1'b0);
        pc_check(32'h0040_0004, 2);
        check("pc4_addr_direct", 40'(mem_addr_o), 40'd1);
        check("pc4_fault_direct", 40'(pc_fault_o), 40'd0);
        pc_check(32'h0040_0006, 2);
        check("pc6_fault_direct", 40'(pc_fault_o), 40'd1);
        pc_check(32'h0040_0008, 2);
        check("pc8_fault_direct", 40'(pc_fault_o), 40'd1);
        pc_check(32'h003F_FFFC, 2);
        check("pcneg_fault_direct", 40'(pc_fault_o), 40'd1);
        random_pcs(2, 10);

        // Header out of range, then zero-length header
        boot_pulse();
        bad_header(8'h01, 8'h01);
        boot_pulse();
        bad_header(8'h00, 8'h00);
        boot_pulse();

        // Random images with bus gaps
        for (int unsigned r = 0; r < 4; r++) begin
            n = $urandom_range(1, 12);
            for (int unsigned i = 0; i < n; i++) img[i] = $urandom;
            load_image(n, 1'b1);
            random_pcs(n, 12);
            boot_pulse();
        end

        // Full-depth image
        for (int unsigned i = 0; i < DEPTH; i++) img[i] = $urandom;
        load_image(DEPTH, 1'b1);
        pc_check(BASE + 32'd1020, DEPTH);
        pc_check(BASE + 32'd1024, DEPTH);
        boot_pulse();

        // Reset after 6 data bytes, then a fresh one-word load
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int unsigned i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1);
        @(negedge clk);
        byte_valid_i = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_we", 40'(mem_we_o), 40'd0);
        check("midrst_ready", 40'(byte_ready_o), 40'd1);
        check("midrst_stall", 40'(cpu_stall_o), 40'd1);
        check("midrst_addr", 40'(mem_addr_o), 40'd0);
        reset = 1'b0;
        img[0] = $urandom;
        load_image(1, 1'b1);
        random_pcs(1, 6);

`ifdef LOADER_CHECKSUM_EN
        boot_pulse();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h09, 1'b0);
        idle_bus();
        @(negedge clk);
        check("csum_bad_fault", 40'(fault_o), 40'd1);
        check("csum_bad_stall", 40'(cpu_stall_o), 40'd1);
        boot_pulse();
        img[0] = 32'h1234_5678;
        load_image(1, 1'b0);
        check("csum_good_fault", 40'(fault_o), 40'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
